// File: rtl/rom_loader.sv
// Boot-time image loader: assembles a little-endian byte stream (length header, then words)
// into 32-bit ROM writes at consecutive addresses, holding the CPU until the image is complete.
//
// state   | meaning
// S_LEN   | collecting the 4-byte word-count header
// S_DATA  | collecting the 4 bytes of the next instruction word
// S_WRITE | one-cycle ROM write of the assembled word
// S_DONE  | image written, CPU released; waits for restart
// S_ERR   | header exceeded MAX_WORDS; waits for restart
module rom_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned MAX_WORDS = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   input  logic        restart,
   output logic        rom_we,
   output logic [31:0] rom_waddr,
   output logic [31:0] rom_wdata,
   output logic        cpu_hold,
   output logic        load_done,
   output logic        err_len,
   output logic [31:0] word_count
);

   typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   state_t      state;
   state_t      state_nxt;
   logic [1:0]  byte_cnt;
   logic [31:0] acc;
   logic [31:0] len;
   logic [31:0] word_full;
   logic        accept;
   logic        last_byte;

   assign accept    = in_valid && in_ready;
   assign last_byte = accept && (byte_cnt == 2'd3);
   assign word_full = {in_byte, acc[23:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_LEN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_LEN: begin
            if (last_byte) begin
               if (word_full == 32'd0)      state_nxt = S_DONE;
               else if (word_full > MAX_W)  state_nxt = S_ERR;
               else                         state_nxt = S_DATA;
            end
         end
         S_DATA:  if (last_byte) state_nxt = S_WRITE;
         S_WRITE: state_nxt = (word_count + 32'd1 == len) ? S_DONE : S_DATA;
         S_DONE,
         S_ERR:   if (restart) state_nxt = S_LEN;
         default: state_nxt = S_LEN;
      endcase
   end

   // in_ready is a pure state decode so upstream can never see it follow in_valid
   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_LEN, S_DATA: in_ready = 1'b1;
         default:       in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt   <= 2'd0;
         acc        <= 32'd0;
         len        <= 32'd0;
         rom_we     <= 1'b0;
         rom_waddr  <= BASE_ADDR;
         rom_wdata  <= 32'd0;
         cpu_hold   <= 1'b1;
         load_done  <= 1'b0;
         err_len    <= 1'b0;
         word_count <= 32'd0;
      end else begin
         rom_we <= 1'b0;

         if (state_nxt != state) byte_cnt <= 2'd0;
         else if (accept)        byte_cnt <= byte_cnt + 2'd1;

         if (accept) acc[{byte_cnt, 3'b000} +: 8] <= in_byte;

         if (state_nxt == S_DONE && state != S_DONE) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
         end
         if (state_nxt == S_ERR && state != S_ERR) err_len <= 1'b1;

         case (state)
            S_LEN: if (last_byte) len <= word_full;
            S_DATA: begin
               if (last_byte) begin
                  rom_we    <= 1'b1;
                  rom_wdata <= word_full;
                  rom_waddr <= BASE_ADDR + {word_count[29:0], 2'b00};
               end
            end
            S_WRITE: word_count <= word_count + 32'd1;
            S_DONE, S_ERR: begin
               if (restart) begin
                  word_count <= 32'd0;
                  load_done  <= 1'b0;
                  err_len    <= 1'b0;
                  cpu_hold   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader sitting directly upstream of the instruction memory's write port. It accepts a little-endian byte stream (length header, then instruction words) over a valid/ready handshake, assembles 32-bit words, and issues one ROM write per word at consecutive word addresses. It holds the CPU in reset-hold until the image is fully written, then releases it.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of the first word written
- MAX_WORDS, 4096, largest accepted image length in words; a larger header is an error

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  byte available on in_byte
- in_byte  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- restart  input  1  synchronous request to reload; honoured only in DONE or ERR
- rom_we  output  1  ROM write strobe, one cycle per word
- rom_waddr  output  32  ROM write byte address
- rom_wdata  output  32  ROM write data
- cpu_hold  output  1  1 = CPU must not fetch
- load_done  output  1  image fully written
- err_len  output  1  header exceeded MAX_WORDS
- word_count  output  32  words written so far in the current load

## Operation
- Byte accepted on any cycle with in_valid && in_ready. Bytes arriving with in_ready=0 are not consumed; the upstream source holds them.
- Byte order: little-endian. The k-th accepted byte of a group (k=0..3) lands in bits [8k+7:8k].
- States:
  - S_LEN: in_ready=1; collect 4 header bytes into len. On the 4th byte: len==0 -> S_DONE; len>MAX_WORDS -> S_ERR; else -> S_DATA.
  - S_DATA: in_ready=1; collect 4 bytes into a shift/assembly register; on the 4th byte -> S_WRITE.
  - S_WRITE: in_ready=0; rom_we=1, rom_wdata=assembled word, rom_waddr=BASE_ADDR+4*word_count. Next cycle word_count increments; if new word_count==len -> S_DONE, else -> S_DATA.
  - S_DONE: in_ready=0, load_done=1, cpu_hold=0. restart -> S_LEN.
  - S_ERR: in_ready=0, err_len=1, cpu_hold=1. restart -> S_LEN.
- Byte-in-group counter (2 bits) is cleared on each state entry into S_LEN or S_DATA.
- Entering S_LEN via restart clears word_count, load_done, err_len and re-asserts cpu_hold in the same cycle the state changes.
- restart is ignored in S_LEN, S_DATA and S_WRITE.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no flag; word_count is 32 bits and never exceeds MAX_WORDS.

## Timing
- All outputs are registered except in_ready, which is a decode of state only and never depends on in_valid.
- Reset values: state S_LEN, in_ready=1, rom_we=0, rom_waddr=BASE_ADDR, rom_wdata=0, cpu_hold=1, load_done=0, err_len=0, word_count=0.
- Latency: if the 4th byte of a word is accepted in cycle t, rom_we=1 in cycle t+1. The next byte can be accepted no earlier than t+2. Peak rate is one word per 5 cycles.
- rom_we is high for exactly one cycle per word, and rom_waddr/rom_wdata are stable during that cycle.
- After the last write (cycle w), load_done=1 and cpu_hold=0 in cycle w+1.
- For a zero-length header whose last byte is accepted at t, load_done=1 at t+1.
- Reset asserted mid-load discards any partial word and returns to S_LEN immediately. No rom_we is issued after rst rises.

## Test plan
- Reset check: assert rst during S_DATA with 2 bytes collected -> outputs at reset values next edge; rom_we stays 0; a fresh header is then accepted.
- Basic load: stream 02 00 00 00, 13 05 10 00, 73 00 10 00 with in_valid always 1 -> two writes: waddr 0x80000000/wdata 0x00100513, then waddr 0x80000004/wdata 0x00100073; load_done=1 and cpu_hold=0 one cycle after the second write; word_count=2.
- Backpressure and gaps: same stream with in_valid toggled randomly -> identical writes; in_ready=0 exactly during each write cycle; no byte dropped or duplicated.
- Zero length: header 00 00 00 00 -> no rom_we; load_done=1 one cycle after the 4th byte.
- Overflow: with MAX_WORDS=4, header 05 00 00 00 -> err_len=1, cpu_hold=1, in_ready=0, no writes; restart then reload of length 1, word 0xDEADBEEF -> write at 0x80000000, err_len cleared.
- Restart from DONE: after a 1-word load, pulse restart and load 1 word 0x00000013 -> write at BASE_ADDR again; word_count resets to 0, then reaches 1.
